// File: rtl/conntb_pkg.sv
// Shared types and the PRBS-8 step function for the ConnectTB driver agent.
// The LFSR uses the polynomial x^8+x^6+x^5+x^4+1, which sets feedback taps on bits 7,5,4,3.
package conntb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int LFSR_W = 8;
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 8'hB8;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return {s[LFSR_W-2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/conntb_if.sv
// ConnectTB link: the bench side drives stimulus and observes the DUT's response.
interface ConnectTB;
  logic drive;
  logic observe;
  modport tb  (output drive, input observe);
  modport dut (input drive, output observe);
endinterface

// File: rtl/conntb_lfsr.sv
// 8-bit Fibonacci PRBS generator with a synchronous load and a step enable.
module conntb_lfsr
  import conntb_pkg::*;
#(
  parameter logic [LFSR_W-1:0] RST_SEED = 8'hA5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [LFSR_W-1:0] seed_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RST_SEED;
    end else if (load_i) begin
      state_q <= seed_i;
    end else if (en_i) begin
      state_q <= lfsr_next(state_q);
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/conntb_tb_driver.sv
// Built-in self-test agent: drives a PRBS stream on intf.drive and checks intf.observe
// after a fixed latency, counting mismatches and recording the first failing bit index.
module conntb_tb_driver
  import conntb_pkg::*;
#(
  parameter int                NUM_BITS = 64,
  parameter int                LATENCY  = 0,
  parameter logic [LFSR_W-1:0] SEED     = 8'hA5,
  parameter int                CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  ConnectTB.tb             intf,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_idx
);

  localparam int BIT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(NUM_BITS - 1);
  localparam logic [LAT_W-1:0] LAST_DRAIN = LAT_W'((LATENCY > 0) ? LATENCY - 1 : 0);
  localparam logic [CNT_W-1:0] ALL_ONES   = '1;

  state_e            state_q;
  logic              drive_q, busy_q, done_q, pass_q;
  logic [BIT_W-1:0]  bit_cnt_q;
  logic [LAT_W-1:0]  drain_cnt_q;
  logic [CNT_W-1:0]  err_count_q, err_count_d, first_err_q, first_err_d;
  logic [LFSR_W-1:0] lfsr_state;
  logic              lfsr_unused;
  logic              start_fire, last_bit, cur_valid, mismatch;
  logic              tail_valid, tail_bit;
  logic [CNT_W-1:0]  cur_idx, tail_idx;

  assign start_fire = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_bit   = (state_q == ST_RUN) && (bit_cnt_q == LAST_BIT);
  assign cur_valid  = (state_q == ST_RUN);
  assign cur_idx    = CNT_W'(bit_cnt_q);

  // Bit 0 is driven straight from SEED at the start edge, so the LFSR is preloaded one step ahead.
  conntb_lfsr #(.RST_SEED(SEED)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (start_fire),
    .en_i    (cur_valid && !last_bit),
    .seed_i  (lfsr_next(SEED)),
    .state_o (lfsr_state)
  );
  assign lfsr_unused = ^lfsr_state[LFSR_W-2:0];

  generate
    if (LATENCY == 0) begin : g_nopipe
      assign tail_valid = cur_valid;
      assign tail_bit   = drive_q;
      assign tail_idx   = cur_idx;
    end else begin : g_pipe
      logic             pipe_vld_q [LATENCY];
      logic             pipe_bit_q [LATENCY];
      logic [CNT_W-1:0] pipe_idx_q [LATENCY];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || start_fire) begin
          for (int i = 0; i < LATENCY; i++) begin
            pipe_vld_q[i] <= 1'b0;
            pipe_bit_q[i] <= 1'b0;
            pipe_idx_q[i] <= '0;
          end
        end else begin
          pipe_vld_q[0] <= cur_valid;
          pipe_bit_q[0] <= drive_q;
          pipe_idx_q[0] <= cur_idx;
          for (int i = 1; i < LATENCY; i++) begin
            pipe_vld_q[i] <= pipe_vld_q[i-1];
            pipe_bit_q[i] <= pipe_bit_q[i-1];
            pipe_idx_q[i] <= pipe_idx_q[i-1];
          end
        end
      end

      assign tail_valid = pipe_vld_q[LATENCY-1];
      assign tail_bit   = pipe_bit_q[LATENCY-1];
      assign tail_idx   = pipe_idx_q[LATENCY-1];
    end
  endgenerate

  assign mismatch    = tail_valid && (intf.observe != tail_bit);
  assign err_count_d = (mismatch && (err_count_q != ALL_ONES)) ? err_count_q + CNT_W'(1) : err_count_q;
  assign first_err_d = (mismatch && (first_err_q == ALL_ONES)) ? tail_idx : first_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      drive_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      bit_cnt_q   <= '0;
      drain_cnt_q <= '0;
      err_count_q <= '0;
      first_err_q <= ALL_ONES;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q     <= ST_RUN;
            drive_q     <= SEED[LFSR_W-1];
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            bit_cnt_q   <= '0;
            drain_cnt_q <= '0;
            err_count_q <= '0;
            first_err_q <= ALL_ONES;
          end
        end
        ST_RUN: begin
          err_count_q <= err_count_d;
          first_err_q <= first_err_d;
          if (last_bit) begin
            drive_q <= 1'b0;
            if (LATENCY > 0) begin
              state_q <= ST_DRAIN;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              pass_q  <= (err_count_d == '0);
            end
          end else begin
            drive_q   <= lfsr_state[LFSR_W-1];
            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
          end
        end
        ST_DRAIN: begin
          err_count_q <= err_count_d;
          first_err_q <= first_err_d;
          if (drain_cnt_q == LAST_DRAIN) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_count_d == '0);
          end else begin
            drain_cnt_q <= drain_cnt_q + LAT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign intf.drive    = drive_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_count_q;
  assign first_err_idx = first_err_q;

endmodule
